// File: rtl/dma_priority_arbiter.sv
// DMA priority arbiter.
// Combines the raw hardware requests with the mask and software requests,
// picks a winner in fixed or rotating priority order, and runs the
// hold-request handshake with the CPU (HRQ/HLDA). It drives the channel
// acknowledges while a service is in progress. A one-cycle release gap
// always separates two services.
module dma_priority_arbiter #(
    parameter int unsigned HLDA_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DREQ,
    input  logic [7:0] commandReg,
    input  logic [3:0] maskReg,
    input  logic [3:0] requestReg,
    input  logic       HLDA,
    input  logic       tcDone,
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic       grantValid,
    output logic [1:0] grantChannel,
    output logic       hldaTimeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Counter value in the last REQ cycle before the timeout fires.
    localparam logic [7:0] TIMEOUT_LAST = 8'(HLDA_TIMEOUT - 32'd1);

    state_t     state_r;
    logic [1:0] winner_r;
    logic [1:0] pointer_r;
    logic [7:0] count_r;
    logic       hrq_r;
    logic       grant_valid_r;
    logic [1:0] grant_channel_r;
    logic       hlda_timeout_r;

    logic [3:0] eff_req_s;
    logic [1:0] lowest_s;
    logic [1:0] winner_s;
    logic [3:0] dack_active_s;

    // Command bits that have no meaning for this block.
    logic       unused_cmd_s;
    assign unused_cmd_s = ^{commandReg[5], commandReg[3], commandReg[1:0]};

    // The winner is the first requesting channel found when the scan starts
    // just above 'lowest' and wraps modulo 4. The scan runs from lowest
    // priority to highest, so the last hit is the one that wins.
    function automatic logic [1:0] pick_winner(input logic [3:0] req,
                                               input logic [1:0] lowest);
        logic [1:0] winner;
        logic [1:0] idx;
        winner = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = lowest + 2'(k);
            if (req[idx]) begin
                winner = idx;
            end
        end
        return winner;
    endfunction

    // Effective requests and the channel that would win arbitration right now.
    always_comb begin
        eff_req_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            eff_req_s[i] = ((DREQ[i] ^ commandReg[6]) & ~maskReg[i]) | requestReg[i];
        end
        // Fixed priority behaves like rotation with channel 3 always lowest.
        lowest_s = commandReg[4] ? pointer_r : 2'd3;
        winner_s = pick_winner(eff_req_s, lowest_s);
    end

    // Acknowledge decode from registered state and winner; polarity is applied last.
    always_comb begin
        dack_active_s = 4'b0000;
        if (state_r == SERVE) begin
            dack_active_s = 4'b0001 << winner_r;
        end else begin
            dack_active_s = 4'b0000;
        end
        DACK = commandReg[7] ? dack_active_s : ~dack_active_s;
    end

    // Arbitration FSM with the HLDA timeout counter and the registered handshake outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r         <= IDLE;
            winner_r        <= 2'd0;
            pointer_r       <= 2'd3;
            count_r         <= 8'd0;
            hrq_r           <= 1'b0;
            grant_valid_r   <= 1'b0;
            grant_channel_r <= 2'd0;
            hlda_timeout_r  <= 1'b0;
        end else begin
            hlda_timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    count_r       <= 8'd0;
                    grant_valid_r <= 1'b0;
                    if (!commandReg[2] && (eff_req_s != 4'b0000)) begin
                        state_r         <= REQ;
                        winner_r        <= winner_s;
                        hrq_r           <= 1'b1;
                        grant_channel_r <= winner_s;
                    end else begin
                        state_r         <= IDLE;
                        hrq_r           <= 1'b0;
                        grant_channel_r <= 2'd0;
                    end
                end
                REQ: begin
                    // The winner stays locked here. HLDA wins over both
                    // the timeout and a dropped request.
                    if (HLDA) begin
                        state_r       <= SERVE;
                        grant_valid_r <= 1'b1;
                        count_r       <= 8'd0;
                    end else if (count_r == TIMEOUT_LAST) begin
                        state_r         <= IDLE;
                        hrq_r           <= 1'b0;
                        grant_channel_r <= 2'd0;
                        count_r         <= 8'd0;
                        hlda_timeout_r  <= 1'b1;
                    end else if (!eff_req_s[winner_r]) begin
                        state_r         <= IDLE;
                        hrq_r           <= 1'b0;
                        grant_channel_r <= 2'd0;
                        count_r         <= 8'd0;
                    end else begin
                        count_r <= count_r + 8'd1;
                    end
                end
                SERVE: begin
                    // Request changes and the disable bit do not end service.
                    // Only a terminal count or a lost HLDA does.
                    if (tcDone || !HLDA) begin
                        state_r         <= RELEASE;
                        hrq_r           <= 1'b0;
                        grant_valid_r   <= 1'b0;
                        grant_channel_r <= 2'd0;
                        if (commandReg[4]) begin
                            pointer_r <= winner_r;
                        end else begin
                            pointer_r <= pointer_r;
                        end
                    end else begin
                        state_r <= SERVE;
                    end
                end
                RELEASE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r         <= IDLE;
                    hrq_r           <= 1'b0;
                    grant_valid_r   <= 1'b0;
                    grant_channel_r <= 2'd0;
                    count_r         <= 8'd0;
                end
            endcase
        end
    end

    assign HRQ          = hrq_r;
    assign grantValid   = grant_valid_r;
    assign grantChannel = grant_channel_r;
    assign hldaTimeout  = hlda_timeout_r;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed scenarios followed
// by randomized services checked against a transaction-level priority model.
module tb_dma_priority_arbiter;

    logic       CLK;
    logic       RESET;
    logic [3:0] DREQ;
    logic [7:0] commandReg;
    logic [3:0] maskReg;
    logic [3:0] requestReg;
    logic       HLDA;
    logic       tcDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantChannel;
    logic       hldaTimeout;

    int tests = 0;
    int fails = 0;
    // Model of the rotating pointer: the lowest-priority channel.
    int model_ptr = 3;

    dma_priority_arbiter #(.HLDA_TIMEOUT(15)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .DREQ         (DREQ),
        .commandReg   (commandReg),
        .maskReg      (maskReg),
        .requestReg   (requestReg),
        .HLDA         (HLDA),
        .tcDone       (tcDone),
        .HRQ          (HRQ),
        .DACK         (DACK),
        .grantValid   (grantValid),
        .grantChannel (grantChannel),
        .hldaTimeout  (hldaTimeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_eff(input logic [7:0] cmd, input logic [3:0] dreq,
                                             input logic [3:0] mask, input logic [3:0] rq);
        logic [3:0] e;
        for (int i = 0; i < 4; i++) begin
            e[i] = ((dreq[i] != cmd[6]) && !mask[i]) || rq[i];
        end
        return e;
    endfunction

    // Walk the priority list from highest to lowest; -1 when nothing requests.
    function automatic int model_pick(input logic [3:0] e, input logic rot);
        int low;
        int c;
        low = rot ? model_ptr : 3;
        for (int k = 1; k <= 4; k++) begin
            c = (low + k) % 4;
            if (e[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_dack(input int ch, input logic active_high);
        logic [3:0] onehot;
        onehot = 4'b0000;
        if (ch >= 0) onehot[ch] = 1'b1;
        return active_high ? onehot : ~onehot;
    endfunction

    // One full service starting from IDLE. It returns the granted channel
    // (-1 if none) and the DACK pattern seen in SERVE.
    // endm: 0 = tcDone, 1 = HLDA drop, 2 = both in the same cycle.
    task automatic serve_txn(input logic [7:0] cmd, input logic [3:0] dreq,
                             input logic [3:0] mask, input logic [3:0] rq,
                             input int extra, input int endm,
                             output int ch, output logic [3:0] sdack);
        logic [3:0] e;
        int         exp_ch;
        commandReg = cmd;
        DREQ       = dreq;
        maskReg    = mask;
        requestReg = rq;
        e          = model_eff(cmd, dreq, mask, rq);
        exp_ch     = model_pick(e, cmd[4]);
        ch         = -1;
        sdack      = model_dack(-1, cmd[7]);
        tick();
        if (cmd[2] || (e == 4'b0000)) begin
            check("idle_no_hrq", 32'(HRQ), 32'd0);
            check("idle_no_valid", 32'(grantValid), 32'd0);
            return;
        end
        check("req_hrq", 32'(HRQ), 32'd1);
        check("req_valid", 32'(grantValid), 32'd0);
        check("req_channel", 32'(grantChannel), 32'(exp_ch));
        check("req_dack", 32'(DACK), 32'(model_dack(-1, cmd[7])));
        HLDA = 1'b1;
        tick();
        check("serve_valid", 32'(grantValid), 32'd1);
        check("serve_hrq", 32'(HRQ), 32'd1);
        check("serve_channel", 32'(grantChannel), 32'(exp_ch));
        check("serve_dack", 32'(DACK), 32'(model_dack(exp_ch, cmd[7])));
        ch    = int'(grantChannel);
        sdack = DACK;
        for (int n = 0; n < extra; n++) begin
            DREQ          = 4'($urandom);
            maskReg       = 4'($urandom);
            requestReg    = 4'($urandom);
            commandReg[2] = 1'($urandom);
            tick();
            check("serve_hold_valid", 32'(grantValid), 32'd1);
            check("serve_hold_dack", 32'(DACK), 32'(model_dack(exp_ch, cmd[7])));
        end
        if (endm == 0) begin
            tcDone = 1'b1;
        end else if (endm == 1) begin
            HLDA = 1'b0;
        end else begin
            tcDone = 1'b1;
            HLDA   = 1'b0;
        end
        tick();
        tcDone     = 1'b0;
        HLDA       = 1'b0;
        commandReg = cmd;
        check("release_hrq", 32'(HRQ), 32'd0);
        check("release_valid", 32'(grantValid), 32'd0);
        check("release_channel", 32'(grantChannel), 32'd0);
        check("release_dack", 32'(DACK), 32'(model_dack(-1, cmd[7])));
        if (cmd[4]) model_ptr = exp_ch;
        tick();
        check("gap_hrq", 32'(HRQ), 32'd0);
        check("gap_valid", 32'(grantValid), 32'd0);
    endtask

    initial begin
        int         ch;
        logic [3:0] sd;
        int         hi;
        int         tos;
        int         rot_order [5] = '{0, 1, 2, 3, 0};
        logic [7:0] cmd;

        RESET = 1'b1; DREQ = 4'b0000; commandReg = 8'h00; maskReg = 4'b0000;
        requestReg = 4'b0000; HLDA = 1'b0; tcDone = 1'b0;
        tick();
        tick();
        check("rst_hrq", 32'(HRQ), 32'd0);
        check("rst_valid", 32'(grantValid), 32'd0);
        check("rst_channel", 32'(grantChannel), 32'd0);
        check("rst_timeout", 32'(hldaTimeout), 32'd0);
        check("rst_dack", 32'(DACK), 32'hF);
        RESET = 1'b0;
        tick();
        check("post_rst_dack", 32'(DACK), 32'hF);

        // Fixed priority: channel 1 beats channel 3.
        serve_txn(8'h00, 4'b1010, 4'b0000, 4'b0000, 1, 0, ch, sd);
        check("fixed_channel", 32'(ch), 32'd1);
        check("fixed_dack", 32'(sd), 32'hD);

        // Rotating priority with all channels requesting.
        for (int i = 0; i < 5; i++) begin
            serve_txn(8'h10, 4'b1111, 4'b0000, 4'b0000, 0, 0, ch, sd);
            check("rot_order", 32'(ch), 32'(rot_order[i]));
        end

        // Reset in the middle of SERVE; the pointer is 0 here, so channel 1 wins.
        commandReg = 8'h10; DREQ = 4'b1111; maskReg = 4'b0000; requestReg = 4'b0000;
        tick();
        check("mid_req_channel", 32'(grantChannel), 32'd1);
        HLDA = 1'b1;
        tick();
        check("mid_serve_valid", 32'(grantValid), 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        HLDA  = 1'b0;
        model_ptr = 3;
        check("mid_rst_hrq", 32'(HRQ), 32'd0);
        check("mid_rst_dack", 32'(DACK), 32'hF);
        check("mid_rst_valid", 32'(grantValid), 32'd0);
        check("mid_rst_channel", 32'(grantChannel), 32'd0);
        serve_txn(8'h10, 4'b1111, 4'b0000, 4'b0000, 0, 0, ch, sd);
        check("mid_rst_next", 32'(ch), 32'd0);

        // tcDone and HLDA end together: one release, pointer advances by one.
        serve_txn(8'h10, 4'b1111, 4'b0000, 4'b0000, 0, 2, ch, sd);
        check("simul_channel", 32'(ch), 32'd1);
        serve_txn(8'h10, 4'b1111, 4'b0000, 4'b0000, 0, 0, ch, sd);
        check("simul_advance", 32'(ch), 32'd2);

        // Active-low DREQ with masking, then a software request on channel 0.
        serve_txn(8'hC0, 4'b1110, 4'b0001, 4'b0000, 0, 0, ch, sd);
        tick();
        check("mask_no_hrq", 32'(HRQ), 32'd0);
        check("mask_no_grant", 32'(ch), 32'hFFFF_FFFF);
        serve_txn(8'hC0, 4'b1110, 4'b0001, 4'b0001, 0, 0, ch, sd);
        check("swreq_channel", 32'(ch), 32'd0);
        check("swreq_dack", 32'(sd), 32'h1);

        // Controller disabled: no arbitration.
        serve_txn(8'h04, 4'b1111, 4'b0000, 4'b0000, 0, 0, ch, sd);
        check("disabled_no_grant", 32'(ch), 32'hFFFF_FFFF);

        // REQ: locked against higher priority, tcDone ignored, request drop returns to IDLE.
        commandReg = 8'h00; DREQ = 4'b0100; maskReg = 4'b0000; requestReg = 4'b0000;
        tick();
        check("lock_channel", 32'(grantChannel), 32'd2);
        DREQ   = 4'b0101;
        tcDone = 1'b1;
        tick();
        tcDone = 1'b0;
        check("lock_hold_hrq", 32'(HRQ), 32'd1);
        check("lock_hold_channel", 32'(grantChannel), 32'd2);
        check("tc_ignored_valid", 32'(grantValid), 32'd0);
        DREQ = 4'b0001;
        tick();
        check("drop_hrq", 32'(HRQ), 32'd0);
        check("drop_channel", 32'(grantChannel), 32'd0);
        check("drop_timeout", 32'(hldaTimeout), 32'd0);

        // HLDA timeout after 15 REQ cycles, then re-arbitration.
        DREQ = 4'b0001;
        tick();
        hi  = 0;
        tos = 0;
        for (int i = 0; i < 40; i++) begin
            if (HRQ !== 1'b1) break;
            hi++;
            if (hldaTimeout === 1'b1) tos++;
            tick();
        end
        check("timeout_cycles", 32'(hi), 32'd15);
        check("timeout_early_pulse", 32'(tos), 32'd0);
        check("timeout_pulse", 32'(hldaTimeout), 32'd1);
        tick();
        check("timeout_pulse_end", 32'(hldaTimeout), 32'd0);
        check("timeout_rearb", 32'(HRQ), 32'd1);
        DREQ = 4'b0000;
        tick();
        check("timeout_cleanup", 32'(HRQ), 32'd0);

        // Randomized services against the model.
        for (int r = 0; r < 40; r++) begin
            cmd    = 8'h00;
            cmd[7] = 1'($urandom);
            cmd[6] = 1'($urandom);
            cmd[4] = 1'($urandom);
            cmd[2] = ($urandom_range(0, 3) == 0);
            serve_txn(cmd, 4'($urandom), 4'($urandom), 4'($urandom & $urandom),
                      $urandom_range(0, 3), $urandom_range(0, 2), ch, sd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 The block SHALL have parameter HLDA_TIMEOUT, default 15, giving the maximum cycles in REQ waiting for HLDA (legal range 1..255).
REQ-002 The block SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port DREQ  input  4  raw channel requests; polarity set by commandReg[6].
REQ-005 The block SHALL have port commandReg  input  8  command register: bit2 controller disable, bit4 rotating priority, bit6 DREQ active-low, bit7 DACK active-high.
REQ-006 The block SHALL have port maskReg  input  4  per-channel hardware request mask (1 = masked).
REQ-007 The block SHALL have port requestReg  input  4  software requests (1 = request), not subject to masking.
REQ-008 The block SHALL have port HLDA  input  1  hold acknowledge from CPU.
REQ-009 The block SHALL have port tcDone  input  1  one-cycle pulse from timing control: current service finished.
REQ-010 The block SHALL have port HRQ  output  1  hold request to CPU.
REQ-011 The block SHALL have port DACK  output  4  channel acknowledges; polarity set by commandReg[7].
REQ-012 The block SHALL have port grantValid  output  1  high while in SERVE.
REQ-013 The block SHALL have port grantChannel  output  2  locked winner in REQ/SERVE; 0 otherwise.
REQ-014 The block SHALL have port hldaTimeout  output  1  one-cycle pulse on REQ timeout.

Function
REQ-015 The effective request for channel i SHALL be ((DREQ[i] XOR commandReg[6]) AND NOT maskReg[i]) OR requestReg[i].
REQ-016 The FSM SHALL have states IDLE, REQ, SERVE, RELEASE; HRQ = 1 in REQ and SERVE only.
REQ-017 In IDLE with commandReg[2]=0 and any effective request, the block SHALL latch the winner and enter REQ next cycle; with commandReg[2]=1 it SHALL stay in IDLE.
REQ-018 With commandReg[4]=0 (fixed priority), channel 0 SHALL be highest and channel 3 lowest.
REQ-019 With commandReg[4]=1 (rotating priority), the block SHALL use a 2-bit pointer naming the lowest-priority channel; priority descends from pointer+1 mod 4; the pointer SHALL load the served channel on exit from SERVE.
REQ-020 The pointer SHALL reset to 3 so both modes give channel 0 highest after reset; it SHALL not update in fixed mode.
REQ-021 In REQ, the winner SHALL stay locked against higher-priority arrivals; if the winner's effective request deasserts before HLDA, the block SHALL return to IDLE with HRQ=0.
REQ-022 In REQ, an 8-bit counter SHALL count cycles without HLDA; on reaching HLDA_TIMEOUT the block SHALL go to IDLE and pulse hldaTimeout for one cycle.
REQ-023 HLDA=1 in REQ SHALL move to SERVE next cycle; HLDA SHALL take precedence over timeout or request drop in the same cycle.
REQ-024 In SERVE, DACK[winner] SHALL be active and all other DACK bits inactive; DREQ changes SHALL not end service.
REQ-025 SERVE SHALL exit to RELEASE on tcDone=1 or HLDA=0; both in the same cycle SHALL cause exactly one exit and one pointer update.
REQ-026 RELEASE SHALL last exactly one cycle with HRQ=0 and DACK all inactive, then go to IDLE, giving a minimum one-cycle gap between services.
REQ-027 DACK inactive SHALL be 4'b1111 when commandReg[7]=0 and 4'b0000 when commandReg[7]=1; DACK SHALL be decoded from registered state, winner and commandReg[7].
REQ-028 Setting commandReg[2]=1 during REQ or SERVE SHALL not abort the current grant; it SHALL only block new arbitration.
REQ-029 A tcDone pulse outside SERVE SHALL be ignored.

Reset
REQ-030 While RESET=1, the block SHALL go to IDLE with HRQ=0, grantValid=0, grantChannel=0, hldaTimeout=0, counter=0 and pointer=3, regardless of state, including mid-SERVE.
REQ-031 After reset with commandReg=0, DACK SHALL read 4'b1111.

Verification
REQ-032 Fixed priority: DREQ=4'b1010, maskReg=0, commandReg=0 -> HRQ next cycle; HLDA -> grantChannel=1, DACK=4'b1101.
REQ-033 Rotating priority: commandReg[4]=1, all four requesting, tcDone after each service -> service order 0,1,2,3,0.
REQ-034 Timeout: HLDA_TIMEOUT=15, request with HLDA held 0 -> HRQ falls after 15 REQ cycles, hldaTimeout pulses once, block re-arbitrates after returning to IDLE.
REQ-035 Masking and polarity: commandReg=8'hC0, DREQ=4'b1110, maskReg=4'b0001 -> no grant; requestReg=4'b0001 -> channel 0 granted with DACK=4'b0001.
REQ-036 Reset mid-SERVE: RESET asserted during SERVE -> next cycle HRQ=0, DACK=4'b1111, grantValid=0, and the next grant follows channel-0-highest order.
REQ-037 Simultaneous end: tcDone and HLDA fall in the same cycle -> a single RELEASE cycle and a pointer advance of exactly one.
